// File: rtl/seven_seg_decode_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_decode_if : segment input / decoded result bundle          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface seven_seg_decode_if;
  logic [6:0] seg;
  logic       ready;
  logic       valid;
  logic [3:0] hex;
  logic       bad;
  logic       overrun;
  logic [7:0] err_cnt;

  modport master (output seg, ready, input valid, hex, bad, overrun, err_cnt);
  modport slave  (input seg, ready, output valid, hex, bad, overrun, err_cnt);
endinterface
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_decode : debounced 7-segment glyph to hex decoder          |
// | Optional error counter: define SEVEN_SEG_DECODE_ERRCNT_EN            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seven_seg_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input wire               clk,
  input wire               reset,
  seven_seg_decode_if.slave bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] c_BLANK  = 7'h7F;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [6:0] r_seg_q;
  logic [7:0] r_cnt;
  logic [6:0] r_last_acc;
  state_t     r_state;
  logic [3:0] r_hex;
  logic       r_bad;
  logic       r_overrun;

  logic       w_accept;
  logic       w_blank;
  logic       w_load;
  logic [3:0] w_dec_hex;
  logic       w_dec_bad;
  state_t     w_state_nxt;
  logic [3:0] w_hex_nxt;
  logic       w_bad_nxt;
  logic       w_ovr_nxt;

  // A pattern is taken once it has been seen for STABLE_CYCLES edges and
  // differs from the last one taken, so a held glyph fires exactly once.
  assign w_accept = (r_cnt == c_STABLE) && (r_seg_q != r_last_acc);
  assign w_blank  = (r_seg_q == c_BLANK);
  assign w_load   = w_accept && !w_blank;

  always_comb begin
    w_dec_hex = 4'h0;
    w_dec_bad = 1'b0;
    case (r_seg_q)
      7'b1000000: w_dec_hex = 4'h0;
      7'b1111001: w_dec_hex = 4'h1;
      7'b0100100: w_dec_hex = 4'h2;
      7'b0110000: w_dec_hex = 4'h3;
      7'b0011001: w_dec_hex = 4'h4;
      7'b0010010: w_dec_hex = 4'h5;
      7'b0000010: w_dec_hex = 4'h6;
      7'b1111000: w_dec_hex = 4'h7;
      7'b0000000: w_dec_hex = 4'h8;
      7'b0011000: w_dec_hex = 4'h9;
      7'b0001000: w_dec_hex = 4'hA;
      7'b0000011: w_dec_hex = 4'hB;
      7'b1000110: w_dec_hex = 4'hC;
      7'b0100001: w_dec_hex = 4'hD;
      7'b0000110: w_dec_hex = 4'hE;
      7'b0001110: w_dec_hex = 4'hF;
      7'b1111111: w_dec_bad = 1'b0;
      default:    w_dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg_q    <= c_BLANK;
      r_cnt      <= 8'd0;
      r_last_acc <= c_BLANK;
    end else begin
      r_seg_q <= bus.seg;
      if (bus.seg != r_seg_q)
        r_cnt <= 8'd1;
      else if (r_cnt != c_STABLE)
        r_cnt <= r_cnt + 8'd1;
      if (w_accept)
        r_last_acc <= r_seg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_EMPTY;
      r_hex     <= 4'h0;
      r_bad     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hex     <= w_hex_nxt;
      r_bad     <= w_bad_nxt;
      r_overrun <= w_ovr_nxt;
    end
  end

  // Ready with a simultaneous new result reloads without passing through EMPTY.
  always_comb begin
    w_state_nxt = r_state;
    w_hex_nxt   = r_hex;
    w_bad_nxt   = r_bad;
    w_ovr_nxt   = r_overrun;
    case (r_state)
      S_EMPTY: begin
        if (w_load) begin
          w_state_nxt = S_FULL;
          w_hex_nxt   = w_dec_hex;
          w_bad_nxt   = w_dec_bad;
        end
      end
      S_FULL: begin
        if (w_load) begin
          if (bus.ready) begin
            w_hex_nxt = w_dec_hex;
            w_bad_nxt = w_dec_bad;
          end else begin
            w_ovr_nxt = 1'b1;
          end
        end else if (bus.ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign bus.valid   = (r_state == S_FULL);
  assign bus.hex     = r_hex;
  assign bus.bad     = r_bad;
  assign bus.overrun = r_overrun;

`ifdef SEVEN_SEG_DECODE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      r_err_cnt <= 8'd0;
    else if (w_load && w_dec_bad && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seven_seg_decode : directed self-checking bench                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_seven_seg_decode;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

`ifdef SEVEN_SEG_DECODE_ERRCNT_EN
  localparam logic [7:0] c_ERR_ONE = 8'd1;
`else
  localparam logic [7:0] c_ERR_ONE = 8'd0;
`endif

  logic [6:0] c_GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_decode_if u_if ();

  seven_seg_decode #(.STABLE_CYCLES(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic watch(input int n, output int nvalid, output logic [3:0] last_hex);
    nvalid   = 0;
    last_hex = 4'h0;
    repeat (n) begin
      tick(1);
      if (u_if.valid === 1'b1) begin
        nvalid++;
        last_hex = u_if.hex;
      end
    end
  endtask

  int         nv;
  logic [3:0] lh;

  initial begin
    n_total     = 0;
    n_bad       = 0;
    reset       = 1'b0;
    u_if.seg    = 7'h7F;
    u_if.ready  = 1'b0;
    tick(3);
    check_val("rst_valid",   8'(u_if.valid),   8'd0);
    check_val("rst_hex",     8'(u_if.hex),     8'd0);
    check_val("rst_bad",     8'(u_if.bad),     8'd0);
    check_val("rst_overrun", 8'(u_if.overrun), 8'd0);
    check_val("rst_errcnt",  u_if.err_cnt,     8'd0);
    reset = 1'b1;

    // Basic latency: valid on the 5th edge after the pattern appears.
    u_if.ready = 1'b1;
    u_if.seg   = 7'h30;
    tick(4);
    check_val("lat_early", 8'(u_if.valid), 8'd0);
    tick(1);
    check_val("lat_valid", 8'(u_if.valid), 8'd1);
    check_val("lat_hex",   8'(u_if.hex),   8'd3);
    check_val("lat_bad",   8'(u_if.bad),   8'd0);
    tick(1);
    check_val("lat_drop",  8'(u_if.valid), 8'd0);

    // Short glitch is ignored.
    u_if.seg = 7'h02;
    watch(3, nv, lh);
    check_val("glitch_none", 8'(nv), 8'd0);
    u_if.seg = 7'h0E;
    watch(10, nv, lh);
    check_val("glitch_cnt", 8'(nv), 8'd1);
    check_val("glitch_hex", 8'(lh), 8'hF);

    // Full decode table.
    for (int i = 0; i < 16; i++) begin
      u_if.seg = c_GLYPH[i];
      tick(4);
      check_val($sformatf("tbl%0d_early", i), 8'(u_if.valid), 8'd0);
      tick(1);
      check_val($sformatf("tbl%0d_valid", i), 8'(u_if.valid), 8'd1);
      check_val($sformatf("tbl%0d_hex", i),   8'(u_if.hex),   8'(i));
      check_val($sformatf("tbl%0d_bad", i),   8'(u_if.bad),   8'd0);
      tick(1);
    end

    // Held glyph fires once; blank re-arms it.
    u_if.seg = 7'h79;
    watch(20, nv, lh);
    check_val("hold_cnt", 8'(nv), 8'd1);
    check_val("hold_hex", 8'(lh), 8'd1);
    u_if.seg = 7'h7F;
    watch(5, nv, lh);
    check_val("blank_cnt", 8'(nv), 8'd0);
    u_if.seg = 7'h79;
    watch(8, nv, lh);
    check_val("rearm_cnt", 8'(nv), 8'd1);
    check_val("rearm_hex", 8'(lh), 8'd1);

    // Overrun: second result dropped while held.
    u_if.ready = 1'b0;
    u_if.seg   = 7'h24;
    tick(5);
    u_if.seg   = 7'h00;
    tick(6);
    check_val("ovr_valid", 8'(u_if.valid),   8'd1);
    check_val("ovr_hex",   8'(u_if.hex),     8'd2);
    check_val("ovr_flag",  8'(u_if.overrun), 8'd1);
    u_if.ready = 1'b1;
    tick(1);
    check_val("ovr_drain",  8'(u_if.valid),   8'd0);
    check_val("ovr_sticky", 8'(u_if.overrun), 8'd1);

    // Bad pattern.
    u_if.ready = 1'b0;
    u_if.seg   = 7'h55;
    tick(5);
    check_val("bad_valid",  8'(u_if.valid), 8'd1);
    check_val("bad_flag",   8'(u_if.bad),   8'd1);
    check_val("bad_hex",    8'(u_if.hex),   8'd0);
    check_val("bad_errcnt", u_if.err_cnt,   c_ERR_ONE);

    // Reset while FULL, pattern still applied.
    reset = 1'b0;
    tick(1);
    check_val("rf_valid",   8'(u_if.valid),   8'd0);
    check_val("rf_overrun", 8'(u_if.overrun), 8'd0);
    check_val("rf_errcnt",  u_if.err_cnt,     8'd0);
    reset = 1'b1;
    tick(4);
    check_val("rf_early", 8'(u_if.valid), 8'd0);
    tick(1);
    check_val("rf_reacc", 8'(u_if.valid), 8'd1);
    check_val("rf_bad",   8'(u_if.bad),   8'd1);
    check_val("rf_err",   u_if.err_cnt,   c_ERR_ONE);

    // Reset mid-count discards the partial count.
    u_if.ready = 1'b1;
    tick(1);
    check_val("mc_empty", 8'(u_if.valid), 8'd0);
    u_if.seg = 7'h79;
    tick(3);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
    check_val("mc_early", 8'(u_if.valid), 8'd0);
    tick(1);
    check_val("mc_valid", 8'(u_if.valid), 8'd1);
    check_val("mc_hex",   8'(u_if.hex),   8'd1);
    tick(1);

    // Ready coinciding with a new accept reloads without a bubble.
    u_if.ready = 1'b0;
    u_if.seg   = 7'h12;
    tick(5);
    check_val("nb_first", 8'(u_if.hex), 8'd5);
    u_if.seg = 7'h19;
    tick(4);
    check_val("nb_hold", 8'(u_if.hex), 8'd5);
    u_if.ready = 1'b1;
    tick(1);
    check_val("nb_valid",   8'(u_if.valid),   8'd1);
    check_val("nb_hex",     8'(u_if.hex),     8'd4);
    check_val("nb_overrun", 8'(u_if.overrun), 8'd0);
    tick(1);
    check_val("nb_drain", 8'(u_if.valid), 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
